// File: rtl/pipe_add_n.sv
// pipe_add_n: segmented carry-chain adder, one SEG-bit segment per pipeline stage.
// Each stage adds one segment and passes its carry, the partial sum and the
// operands to the next stage. A final output register holds the complete sum.
// Handshake is valid/ready with a single global advance.
// Optional feature: define PIPE_ADD_SAT_EN to build signed saturation and the
// ovf flag. Without it, ovf is 0 and the result wraps.
module pipe_add_n #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
    localparam int STAGES   = WIDTH / SEG_SAFE;

    generate
        if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0) || (STAGES < 1)) begin : g_bad_cfg
            $error("pipe_add_n: WIDTH must be a positive multiple of SEG and SEG >= 1");
        end
    endgenerate

`ifdef PIPE_ADD_SAT_EN
    // Two's-complement overflow: equal operand signs, differing result sign.
    function automatic logic ovf_fn(input logic sign_a, input logic sign_b,
                                    input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    // Clamp to the most positive or most negative value on overflow.
    function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] sum,
                                                input logic ovf_v,
                                                input logic neg);
        if (!ovf_v)
            return sum;
        else if (neg)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // Stage registers: valid, carry, partial sum and operands travelling together.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] cy_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    // Output register.
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             c_out_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;

    // Whole pipeline moves together; stalled output freezes every stage.
    logic advance;
    assign advance = !out_valid_q || out_ready;

    // Per-stage segment addition: stage 0 from the inputs, stage k from stage k-1.
    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [SEG_SAFE:0] seg_sum;
        int               pk;
        src_a   = '0;
        src_b   = '0;
        src_s   = '0;
        src_c   = 1'b0;
        seg_sum = '0;
        pk      = 0;
        cy_d    = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = '0;
            a_d[k]   = '0;
            b_d[k]   = '0;
        end
        for (int k = 0; k < STAGES; k++) begin
            pk = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                src_a = a;
                src_b = b;
                src_s = '0;
                src_c = c_in;
            end else begin
                src_a = a_q[pk];
                src_b = b_q[pk];
                src_s = sum_q[pk];
                src_c = cy_q[pk];
            end
            seg_sum = {1'b0, src_a[k*SEG_SAFE +: SEG_SAFE]}
                    + {1'b0, src_b[k*SEG_SAFE +: SEG_SAFE]}
                    + (SEG_SAFE+1)'(src_c);
            sum_d[k] = src_s;
            sum_d[k][k*SEG_SAFE +: SEG_SAFE] = seg_sum[SEG_SAFE-1:0];
            cy_d[k]  = seg_sum[SEG_SAFE];
            a_d[k]   = src_a;
            b_d[k]   = src_b;
        end
    end

    // Final result formatting: optional saturation on the completed sum.
    always_comb begin
        result_d = sum_q[STAGES-1];
        ovf_d    = 1'b0;
`ifdef PIPE_ADD_SAT_EN
        ovf_d    = ovf_fn(a_q[STAGES-1][WIDTH-1], b_q[STAGES-1][WIDTH-1],
                          sum_q[STAGES-1][WIDTH-1]);
        result_d = sat_fn(sum_q[STAGES-1], ovf_d, a_q[STAGES-1][WIDTH-1]);
`endif
    end

    // Stage valid bits: cleared by reset so in-flight data is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld_q[k] <= vld_q[k-1];
        end
    end

    // Stage datapath registers: no reset needed, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                cy_q[k]  <= cy_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    // Output register: loads the last stage on advance, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= vld_q[STAGES-1];
            result_q    <= result_d;
            c_out_q     <= cy_q[STAGES-1];
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule
